// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit. Holds the RV32I
//               funct3 encodings, the FSM state type, the response error
//               codes and the request classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] c_F3_LB  = 3'd0;
    localparam logic [2:0] c_F3_LH  = 3'd1;
    localparam logic [2:0] c_F3_LW  = 3'd2;
    localparam logic [2:0] c_F3_LBU = 3'd4;
    localparam logic [2:0] c_F3_LHU = 3'd5;

    // Store funct3 encodings
    localparam logic [2:0] c_F3_SB  = 3'd0;
    localparam logic [2:0] c_F3_SH  = 3'd1;
    localparam logic [2:0] c_F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FAULT    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    // Classify a request; illegal beats misaligned beats access fault.
    // funct3[1:0] gives the access size for every legal encoding
    // (00 byte, 01 half, 10 word).
    function automatic lsu_err_e classify(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] offset,
        input logic       fault
    );
        logic     illegal;
        logic     misaligned;
        lsu_err_e result;
        illegal    = we ? (funct3 > c_F3_SW)
                        : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        misaligned = (funct3[1:0] == 2'b01 && offset[0])
                  || (funct3[1:0] == 2'b10 && offset != 2'b00);
        if (illegal)         result = ERR_ILLEGAL;
        else if (misaligned) result = ERR_MISALIGN;
        else if (fault)      result = ERR_FAULT;
        else                 result = ERR_OK;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane
// Description : Combinational byte/half lane logic. Extracts and extends the
//               addressed lane of a memory word for loads, and merges store
//               data into a memory word for sub-word stores.
// Revision    : 1.0 - initial release
// Ports       : i_word      - memory word being read
//               i_offset    - byte offset inside the word
//               i_funct3    - RV32I funct3 of the access
//               i_sdata     - store data (low byte/half used for SB/SH)
//               o_load_data - extended load result
//               o_merged    - word to write back for SB/SH/SW
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_sdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_funct3)
            c_F3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LW:  o_load_data = i_word;
            c_F3_LBU: o_load_data = {24'd0, w_byte};
            c_F3_LHU: o_load_data = {16'd0, w_half};
            default:  o_load_data = 32'd0;
        endcase
    end

    // The memory has no byte enables, so sub-word stores rewrite the
    // whole word with the untouched lanes taken from the read value.
    always_comb begin
        o_merged = i_word;
        case (i_funct3)
            c_F3_SB: begin
                case (i_offset)
                    2'd0:    o_merged[7:0]   = i_sdata[7:0];
                    2'd1:    o_merged[15:8]  = i_sdata[7:0];
                    2'd2:    o_merged[23:16] = i_sdata[7:0];
                    default: o_merged[31:24] = i_sdata[7:0];
                endcase
            end
            c_F3_SH: begin
                if (i_offset[1]) o_merged[31:16] = i_sdata[15:0];
                else             o_merged[15:0]  = i_sdata[15:0];
            end
            default: o_merged = i_sdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of a single-port word-addressed data memory.
//               Accepts RV32I loads/stores over valid/ready, performs
//               alignment/range/funct3 checks, lane extraction with
//               extension, read-modify-write for SB/SH, and returns one
//               response per request over valid/ready.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (async, active-high)
//               req_*  - request channel from execute stage
//               rsp_*  - response channel back to execute stage
//               mem_*  - data memory (combinational read data)
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        state_q,     state_d;
    logic              we_q,        we_d;
    logic [2:0]        funct3_q,    funct3_d;
    logic [1:0]        off_q,       off_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    lsu_err_e          rsp_err_q,   rsp_err_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [31:0]       wdata_mem_q, wdata_mem_d;
    logic [ADDR_W-1:0] raddr_q,     raddr_d;

    logic              w_fault;
    lsu_err_e          w_err;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    // Anything outside the aligned window of 2**ADDR_W words is a fault.
    assign w_fault = (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    assign w_err   = classify(req_we, req_funct3, req_addr[1:0], w_fault);

    lsu_lane u_lane (
        .i_word      (mem_read_data),
        .i_offset    (off_q),
        .i_funct3    (funct3_q),
        .i_sdata     (wdata_q),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_d    = 1'b0;
        waddr_d     = waddr_q;
        wdata_mem_d = wdata_mem_q;
        raddr_d     = raddr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    idx_d    = req_addr[ADDR_W+1:2];
                    wdata_d  = req_wdata;
                    if (w_err != ERR_OK) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = w_err;
                    end else begin
                        raddr_d = req_addr[ADDR_W+1:2];
                        if (req_we && req_funct3 == c_F3_SW) begin
                            // Full-word store needs no read; write next cycle.
                            state_d     = ST_WRITE;
                            mem_we_d    = 1'b1;
                            waddr_d     = req_addr[ADDR_W+1:2];
                            wdata_mem_d = req_wdata;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (!we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = w_load_data;
                    rsp_err_d   = ERR_OK;
                end else begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    waddr_d     = idx_q;
                    wdata_mem_d = w_merged;
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = ERR_OK;
            end
            default: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= ERR_OK;
            mem_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_mem_q <= 32'd0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            waddr_q     <= waddr_d;
            wdata_mem_q <= wdata_mem_d;
            raddr_q     <= raddr_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mem_we         = mem_we_q;
    assign mem_write_addr = waddr_q;
    assign mem_write_data = wdata_mem_q;
    assign mem_read_addr  = raddr_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the single-port word-addressed data memory interface (separate write and read address, write enable, combinational read data). Accepts RV32I load/store requests from the execute stage over a valid/ready handshake and drives the data memory. Performs byte/half extraction with sign or zero extension, read-modify-write for SB/SH (the memory has no byte enables), and alignment/range checks. Returns one response per request over a valid/ready handshake.

Parameters:
ADDR_W, 5, word-address width of the data memory (depth 2**ADDR_W words)
BASE_ADDR, 32'h0000_0000, byte base address of the memory window; must be aligned to 4*2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
mem_write_addr  out  ADDR_W  memory write word address
mem_write_data  out  32  memory write data
mem_we  out  1  memory write enable
mem_read_addr  out  ADDR_W  memory read word address
mem_read_data  in  32  memory read data (combinational from mem_read_addr)

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 00, mem_we 0, both memory addresses 0, mem_write_data 0.
- req_ready = 1 only in IDLE. On accept, register we, funct3, byte offset addr[1:0], word index addr[ADDR_W+1:2], wdata.
- Checks at accept, priority illegal > misaligned > fault: illegal = load funct3 3/6/7 or store funct3 3..7; misaligned = half with addr[0]=1, word with addr[1:0]!=0; fault = addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]. Any error -> RESP with rsp_err set, no memory access.
- IDLE -> READ for loads and SB/SH; IDLE -> WRITE for SW.
- READ: mem_read_addr = word index; capture mem_read_data. Load: extract lane by offset, sign-extend (LB/LH) or zero-extend (LBU/LHU), -> RESP. SB/SH: merge store byte/half into captured word at offset, -> WRITE.
- WRITE: mem_we = 1 for exactly this one cycle, mem_write_addr = word index, mem_write_data = merged word (SB/SH) or wdata (SW); -> RESP.
- RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable until rsp_ready; on handshake -> IDLE. No new request accepted in the same cycle (req_ready 0).
- Latency from accept cycle N: error rsp_valid at N+1; load N+2; SW N+2 (write at N+1); SB/SH N+3 (read N+1, write N+2).
- mem_we is 0 in every state except WRITE. mem_read_addr holds the word index outside READ.
- Reset mid-operation: immediate return to IDLE, mem_we deasserts asynchronously, pending RMW discarded, no response issued.

Decomposition:
- Package lsu_pkg: funct3 constants (LB..LHU, SB/SH/SW), FSM state enum, rsp_err enum.
- Sub-module lsu_lane: combinational load extract/extend and store merge (inputs: word, offset, funct3, store data).

Test Plan:
- Memory all zero; SW 0x08 data 0xDEADBEEF -> mem_we one cycle at N+1, addr 2, data 0xDEADBEEF; rsp N+2 err 00 rdata 0; then LW 0x08 -> rdata 0xDEADBEEF at N+2.
- Extraction on word 0xDEADBEEF: LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x0A -> 0xFFFFDEAD; LHU 0x08 -> 0x0000BEEF.
- RMW: SB 0x09 wdata 0x00000055 -> write 0xDEAD55EF at N+2, rsp N+3; then SH 0x0A wdata 0x00001234 -> 0x123455EF.
- Errors: LW 0x06 -> err 01 at N+1; SH 0x81 -> err 01; LW 0x80 (ADDR_W=5) -> err 10; req_we=0 funct3 3 -> err 11; mem_we never asserted in any case.
- Backpressure: rsp_ready low 5 cycles after a load -> rsp_valid, rsp_rdata, rsp_err stable, req_ready 0, asserted req_valid not accepted; accepted in the cycle after the handshake.
- Reset asserted in READ of an SB -> mem_we never asserted, memory word unchanged, state IDLE, rsp_valid 0, req_ready 1 after reset release.
